// File: rtl/ghash_pkg.sv
// Shared GHASH definitions: state encoding, reduction constant and the GF(2^128) multiplier.
package ghash_pkg;

    localparam int unsigned NB_DATA_DEF = 128;
    localparam int unsigned CNT_W       = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_BLK = 2'd1;
    localparam logic [1:0] ST_MULT     = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_BLK = ST_WAIT_BLK,
        MULT     = ST_MULT,
        DONE     = ST_DONE
    } state_t;

    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in GCM (reflected) bit order.
    localparam logic [127:0] R_POLY = {8'he1, 120'd0};

    // Shift-and-add GF(2^128) product; bit 127 of each operand is the x^0 coefficient.
    function automatic logic [127:0] gf128_mul(input logic [127:0] a, input logic [127:0] h);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = h;
        for (int i = 127; i >= 0; i--) begin
            if (a[i]) begin
                z = z ^ v;
            end
            if (v[0]) begin
                v = (v >> 1) ^ R_POLY;
            end else begin
                v = v >> 1;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/ghash_mult_stage.sv
// Combinational GF(2^128) multiplier followed by MULT_STAGES-1 optional output registers.
module ghash_mult_stage
    import ghash_pkg::*;
#(
    parameter int unsigned NB_DATA     = NB_DATA_DEF,
    parameter int unsigned MULT_STAGES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NB_DATA-1:0] a_reg_i,
    input  logic [NB_DATA-1:0] h_reg_i,
    output logic [NB_DATA-1:0] product_o
);

    logic [NB_DATA-1:0] prod_c;

    assign prod_c = gf128_mul(a_reg_i, h_reg_i);

    if (MULT_STAGES > 1) begin : g_pipe
        localparam int unsigned NREG = MULT_STAGES - 1;

        logic [NB_DATA-1:0] pipe_q [NREG];

        // Retiming registers behind the multiplier; operands are stable for the whole MULT window.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int unsigned k = 0; k < NREG; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                pipe_q[0] <= prod_c;
                for (int unsigned k = 1; k < NREG; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign product_o = pipe_q[NREG-1];
    end else begin : g_comb
        // With no output stages, clock and reset have no load here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign product_o      = prod_c;
    end

endmodule

// File: rtl/ghash_accum_sequencer.sv
// GHASH accumulator: Y_i = (Y_{i-1} ^ X_i) * H over a valid/ready block stream, one shared multiplier.
module ghash_accum_sequencer
    import ghash_pkg::*;
#(
    parameter int unsigned NB_DATA     = NB_DATA_DEF,
    parameter int unsigned MULT_STAGES = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_hkey,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_last,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_ghash
);

    if (NB_DATA != 128) begin : g_bad_width
        $error("ghash_accum_sequencer: NB_DATA must be 128");
    end
    if (MULT_STAGES < 1 || MULT_STAGES > 4) begin : g_bad_stages
        $error("ghash_accum_sequencer: MULT_STAGES must be 1..4");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_STAGES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0] y_q, y_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] h_q, h_d;
    logic               last_q, last_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NB_DATA-1:0] ghash_q, ghash_d;
    logic [NB_DATA-1:0] prod_c;

    ghash_mult_stage #(
        .NB_DATA     (NB_DATA),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk_i     (i_clock),
        .rst_i     (i_reset),
        .a_reg_i   (a_q),
        .h_reg_i   (h_q),
        .product_o (prod_c)
    );

    // State, datapath and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            a_q     <= '0;
            h_q     <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ghash_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            a_q     <= a_d;
            h_q     <= h_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ghash_q <= ghash_d;
        end
    end

    // Next-state and datapath updates; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        a_d     = a_q;
        h_d     = h_q;
        last_d  = last_q;
        ghash_d = ghash_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    h_d     = i_hkey;
                    y_d     = '0;
                    state_d = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                if (i_valid && ready_q) begin
                    a_d     = y_q ^ i_data;
                    last_d  = i_last;
                    cnt_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    y_d = prod_c;
                    if (last_q) begin
                        ghash_d = prod_c;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_BLK;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything except reset; the last published hash survives.
        if (i_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
            ghash_d = ghash_q;
        end

        ready_d = (state_d == WAIT_BLK);
        busy_d  = (state_d == WAIT_BLK) || (state_d == MULT);
        done_d  = (state_d == DONE);
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_ghash = ghash_q;

endmodule

// File: tb/tb_ghash_accum_sequencer.sv
// Scoreboard bench: four DUT copies (MULT_STAGES 1..4) against a polynomial-arithmetic GHASH model.
`timescale 1ns/1ps
module tb_ghash_accum_sequencer;

    localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C1   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] LEN1 = 128'h00000000000000000000000000000080;
    localparam logic [127:0] G2   = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] G3   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    typedef struct {
        logic [127:0] ghash;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit drv_done [4];

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rev128(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = v[127-i];
        return r;
    endfunction

    // Plain polynomial product: reflect to natural order, carry-less multiply, reduce, reflect back.
    function automatic logic [127:0] ref_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] a;
        logic [127:0] b;
        logic [254:0] p;
        a = rev128(x);
        b = rev128(y);
        p = '0;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) p = p ^ (255'(a) << i);
        end
        for (int i = 254; i >= 128; i--) begin
            if (p[i]) begin
                p[i]       = 1'b0;
                p[i - 121] = ~p[i - 121];
                p[i - 126] = ~p[i - 126];
                p[i - 127] = ~p[i - 127];
                p[i - 128] = ~p[i - 128];
            end
        end
        return rev128(p[127:0]);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int MS = g + 1;

        logic         rst, clr, start, valid, last;
        logic         ready, busy, done;
        logic [127:0] hkey, data, ghash;
        int           cyc = 0;
        exp_t         sb[$];
        logic [127:0] y_m, h_m, last_ghash;

        ghash_accum_sequencer #(
            .NB_DATA     (128),
            .MULT_STAGES (MS)
        ) dut (
            .i_clock (clk),
            .i_reset (rst),
            .i_clear (clr),
            .i_start (start),
            .i_hkey  (hkey),
            .i_valid (valid),
            .i_data  (data),
            .i_last  (last),
            .o_ready (ready),
            .o_busy  (busy),
            .o_done  (done),
            .o_ghash (ghash)
        );

        always @(posedge clk) cyc <= cyc + 1;

        task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
            check_eq($sformatf("MS=%0d %s", MS, name), act, exp);
        endtask

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input int n);
            repeat (n) step();
        endtask

        task automatic do_start(input logic [127:0] h);
            hkey  = h;
            start = 1'b1;
            step();
            start = 1'b0;
            h_m   = h;
            y_m   = '0;
        endtask

        // Present one block and wait for its handshake; k is the edge index where it was taken.
        task automatic send(input logic [127:0] x, input bit lst, input bit keep_valid, output int k);
            bit hs;
            bit got;
            got   = 1'b0;
            valid = 1'b1;
            data  = x;
            last  = lst;
            for (int n = 0; n < 64; n++) begin
                hs = ready;
                step();
                if (hs) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("handshake_timeout", 128'(got), 128'd1);
            k = cyc;
            if (!keep_valid) valid = 1'b0;
            y_m = ref_mul(y_m ^ x, h_m);
        endtask

        task automatic expect_done(input logic [127:0] g_exp, input int k);
            sb.push_back('{ghash: g_exp, cyc: k + MS});
            last_ghash = g_exp;
        endtask

        task automatic wait_ready();
            int n;
            n = 0;
            while (!ready && n < 32) begin
                n++;
                step();
            end
            chk("wait_ready_timeout", 128'(ready), 128'd1);
        endtask

        // Monitor: every done strobe must match the head of the scoreboard, value and cycle.
        always @(posedge clk) begin
            #1;
            if (done === 1'b1) begin
                chk("done_expected", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ghash", ghash, e.ghash);
                    chk("done_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end

        initial begin
            int k, prev_k, n, nb;
            rst = 1'b1; clr = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
            hkey = '0; data = '0; y_m = '0; h_m = '0; last_ghash = '0;
            idle(3);
            chk("rst_ready", 128'(ready), 128'd0);
            chk("rst_busy",  128'(busy),  128'd0);
            chk("rst_done",  128'(done),  128'd0);
            chk("rst_ghash", ghash, 128'd0);
            rst = 1'b0;
            step();

            // Single block with known vector.
            do_start(H1);
            chk("busy_after_start", 128'(busy), 128'd1);
            send(C1, 1'b1, 1'b0, k);
            expect_done(G2, k);
            idle(MS + 2);

            // Two blocks with known vector.
            do_start(H1);
            send(C1, 1'b0, 1'b0, k);
            send(LEN1, 1'b1, 1'b0, k);
            expect_done(G3, k);
            idle(MS + 2);

            // Zero key; ready must stay low for exactly MS samples after each handshake.
            do_start('0);
            for (int b = 0; b < 3; b++) begin
                send(rand128(), b == 2, 1'b0, k);
                if (b < 2) begin
                    n = 0;
                    while (!ready && n < 32) begin
                        n++;
                        step();
                    end
                    chk("ready_low_cycles", 128'(n), 128'(MS));
                end
            end
            expect_done('0, k);
            idle(MS + 2);

            // Continuous valid, a start with another key during MULT, throughput check.
            do_start(rand128());
            prev_k = 0;
            for (int b = 0; b < 4; b++) begin
                send(rand128(), b == 3, b != 3, k);
                if (b > 0) chk("throughput", 128'(k - prev_k), 128'(MS + 1));
                prev_k = k;
                if (b == 0) begin
                    hkey  = rand128();
                    start = 1'b1;
                    step();
                    start = 1'b0;
                end
            end
            expect_done(y_m, k);
            idle(MS + 2);

            // Random streams with random gaps; valid may rise while the multiplier is busy.
            for (int s = 0; s < 8; s++) begin
                do_start(rand128());
                nb = int'($urandom_range(1, 5));
                for (int b = 0; b < nb; b++) begin
                    idle(int'($urandom_range(0, 2)));
                    send(rand128(), b == nb - 1, 1'b0, k);
                end
                expect_done(y_m, k);
                idle(MS + 2 + int'($urandom_range(0, 2)));
            end

            // Clear together with start while waiting for the second block.
            do_start(H1);
            send(C1, 1'b0, 1'b0, k);
            wait_ready();
            clr   = 1'b1;
            start = 1'b1;
            hkey  = rand128();
            step();
            clr   = 1'b0;
            start = 1'b0;
            chk("clr_ready", 128'(ready), 128'd0);
            chk("clr_busy",  128'(busy),  128'd0);
            chk("clr_ghash", ghash, last_ghash);
            idle(MS + 3);
            chk("clr_start_dropped", 128'(ready), 128'd0);
            chk("clr_ghash_held", ghash, last_ghash);
            do_start(H1);
            send(C1, 1'b0, 1'b0, k);
            send(LEN1, 1'b1, 1'b0, k);
            expect_done(G3, k);
            idle(MS + 2);

            // Reset one cycle into MULT.
            do_start(rand128());
            send(rand128(), 1'b0, 1'b0, k);
            step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("mid_rst_ready", 128'(ready), 128'd0);
            chk("mid_rst_busy",  128'(busy),  128'd0);
            chk("mid_rst_done",  128'(done),  128'd0);
            chk("mid_rst_ghash", ghash, 128'd0);
            idle(MS + 3);
            chk("mid_rst_idle_ready", 128'(ready), 128'd0);

            chk("scoreboard_drained", 128'(sb.size()), 128'd0);
            drv_done[g] = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(posedge clk);
            all_done = drv_done[0] && drv_done[1] && drv_done[2] && drv_done[3];
        end
        check_eq("drivers_finished", 128'(all_done), 128'd1);
        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
